// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad emulator and the matching decoder:
// FSM states, key matrix map, LFSR taps and idle row level.
package keypad_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPressBounce,
    StHold,
    StReleaseBounce,
    StGap
  } state_e;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  localparam logic [3:0]  RowsIdle = 4'b1111;
  // Feedback taps 16,14,13,11 as bit positions 15,13,12,10.
  localparam logic [15:0] LfsrTaps = 16'hB400;

  // Key code at matrix position {row, col}; the decoder indexes this directly.
  localparam logic [3:0] KeyAtPos [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  function automatic key_pos_t key_to_pos(input logic [3:0] key);
    key_pos_t pos;
    pos = '0;
    for (int i = 0; i < 16; i++) begin
      if (KeyAtPos[i] == key) pos = key_pos_t'(4'(i));
    end
    return pos;
  endfunction

endpackage

// File: rtl/keypad_bounce_lfsr.sv
// Enable-stepped 16-bit Fibonacci LFSR supplying the contact-bounce pattern.
module keypad_bounce_lfsr
  import keypad_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  output logic o_bit
);

  logic [15:0] r_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SEED;
    end else if (i_en) begin
      r_state <= {r_state[14:0], ^(r_state & LfsrTaps)};
    end
  end

  assign o_bit = r_state[0];

endmodule

// File: rtl/keypad_emulator.sv
// Keypad-side responder for the 4x4 column-scan protocol: accepts key commands
// and answers column strobes on the row lines, with bounce around press/release.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 5000000,
  parameter int unsigned BOUNCE_CYCLES = 250000,
  parameter int unsigned BOUNCE_STEP   = 5000,
  parameter int unsigned GAP_CYCLES    = 2500000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] col,
  output logic [3:0] row,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_key,
  output logic       cmd_ready,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MaxHg     = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned MaxCycles = (MaxHg > BOUNCE_CYCLES) ? MaxHg : BOUNCE_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam int unsigned StepW     = $clog2(BOUNCE_STEP + 1);

  localparam logic [CntW-1:0]  HoldLast   = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0]  BounceLast = CntW'(BOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0]  GapLast    = CntW'(GAP_CYCLES - 1);
  localparam logic [CntW-1:0]  ForceFrom  = CntW'(BOUNCE_CYCLES - BOUNCE_STEP);
  localparam logic [StepW-1:0] StepLast   = StepW'(BOUNCE_STEP - 1);

  state_e           r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [StepW-1:0] r_step, w_step_d;
  logic             r_contact, w_contact_d;
  logic [1:0]       r_key_row, r_key_col;
  logic             r_done;
  logic             w_accept, w_phase_last, w_lfsr_en, w_lfsr_bit;
  key_pos_t         w_pos;

  assign w_accept  = cmd_valid && (r_state == StIdle);
  assign w_pos     = key_to_pos(cmd_key);
  assign cmd_ready = (r_state == StIdle);
  assign busy      = (r_state != StIdle);
  assign done      = r_done;

  always_comb begin
    w_phase_last = 1'b0;
    w_state_d    = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_d = StPressBounce;
      end
      StPressBounce: begin
        w_phase_last = (r_cnt == BounceLast);
        if (w_phase_last) w_state_d = StHold;
      end
      StHold: begin
        w_phase_last = (r_cnt == HoldLast);
        if (w_phase_last) w_state_d = StReleaseBounce;
      end
      StReleaseBounce: begin
        w_phase_last = (r_cnt == BounceLast);
        if (w_phase_last) w_state_d = StGap;
      end
      StGap: begin
        w_phase_last = (r_cnt == GapLast);
        if (w_phase_last) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Both counters restart on every state entry; the step counter paces bounce samples.
  always_comb begin
    w_cnt_d  = '0;
    w_step_d = '0;
    if (w_state_d == r_state && r_state != StIdle) begin
      w_cnt_d  = r_cnt + 1'b1;
      w_step_d = (r_step == StepLast) ? '0 : r_step + 1'b1;
    end
  end

  // Contact is computed for the coming cycle, so a bounce sample lands in the entry cycle.
  // The LFSR steps on every bounce sample, including those overridden by the settle window.
  always_comb begin
    w_lfsr_en   = 1'b0;
    w_contact_d = 1'b0;
    unique case (w_state_d)
      StHold: w_contact_d = 1'b1;
      StPressBounce, StReleaseBounce: begin
        w_lfsr_en = (w_step_d == '0);
        if (w_cnt_d >= ForceFrom) begin
          w_contact_d = (w_state_d == StPressBounce);
        end else if (w_lfsr_en) begin
          w_contact_d = w_lfsr_bit;
        end else begin
          w_contact_d = r_contact;
        end
      end
      default: w_contact_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_step    <= '0;
      r_contact <= 1'b0;
      r_key_row <= '0;
      r_key_col <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_step    <= w_step_d;
      r_contact <= w_contact_d;
      r_done    <= (r_state == StGap) && w_phase_last;
      if (w_accept) begin
        r_key_row <= w_pos.row;
        r_key_col <= w_pos.col;
      end
    end
  end

  always_comb begin
    row = RowsIdle;
    if (r_contact && !col[r_key_col]) row[r_key_row] = 1'b0;
  end

  keypad_bounce_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset_n(reset_n),
    .i_en   (w_lfsr_en),
    .o_bit  (w_lfsr_bit)
  );

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: table-driven HOLD probes, hand-written
// reset/bounce/back-to-back sequences and randomized commands against a timeline model.
module tb_keypad_emulator;

  localparam int unsigned Hold   = 100;
  localparam int unsigned Bounce = 16;
  localparam int unsigned Step   = 2;
  localparam int unsigned Gap    = 20;
  localparam int unsigned Busy   = 2 * Bounce + Hold + Gap;
  localparam logic [15:0] Seed   = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] col, row, cmd_key;
  logic       cmd_valid, cmd_ready, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_lfsr;
  logic        m_contact [Busy];
  logic [3:0]  key_tab [16];

  typedef struct {
    logic [3:0] key;
    logic [3:0] col;
    logic [3:0] row;
  } vec_t;
  vec_t vecs [14];

  always #5 clk = ~clk;

  keypad_emulator #(
    .HOLD_CYCLES  (Hold),
    .BOUNCE_CYCLES(Bounce),
    .BOUNCE_STEP  (Step),
    .GAP_CYCLES   (Gap),
    .LFSR_SEED    (Seed)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .col      (col),
    .row      (row),
    .cmd_valid(cmd_valid),
    .cmd_key  (cmd_key),
    .cmd_ready(cmd_ready),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int key_index(input logic [3:0] key);
    for (int i = 0; i < 16; i++) if (key_tab[i] == key) return i;
    return 0;
  endfunction

  function automatic logic [3:0] exp_row(input logic [3:0] key, input logic contact,
                                         input logic [3:0] c);
    int         idx;
    logic [3:0] r;
    idx = key_index(key);
    r   = 4'b1111;
    if (contact && !c[idx % 4]) r[idx / 4] = 1'b0;
    return r;
  endfunction

  task automatic lfsr_draw(output logic b);
    b      = m_lfsr[0];
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  // Contact level for every busy cycle of one command, from the phase lengths.
  task automatic plan_contact();
    logic b;
    int   k;
    b = 1'b0;
    for (int t = 0; t < int'(Busy); t++) begin
      if (t < int'(Bounce)) begin
        k = t;
        if (k % Step == 0) lfsr_draw(b);
        m_contact[t] = (k >= int'(Bounce - Step)) ? 1'b1 : b;
      end else if (t < int'(Bounce + Hold)) begin
        m_contact[t] = 1'b1;
      end else if (t < int'(2 * Bounce + Hold)) begin
        k = t - int'(Bounce + Hold);
        if (k % Step == 0) lfsr_draw(b);
        m_contact[t] = (k >= int'(Bounce - Step)) ? 1'b0 : b;
      end else begin
        m_contact[t] = 1'b0;
      end
    end
  endtask

  // col_mode: 0 rotating strobe, 1 key column held low, 2 random, 3 fixed col_fix.
  task automatic run_cmd(input logic [3:0] key, input int col_mode, input logic [3:0] col_fix,
                         input bit pre_acc, input bit hold_valid, input logic [3:0] next_key,
                         input int probe_t, input logic [3:0] probe_row, input int abort_t,
                         input bit check_bounce);
    int   idx;
    int   stage;
    logic rb;
    idx   = key_index(key);
    stage = 0;
    if (!pre_acc) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_key   = key;
      #1;
      chk1("ready_at_accept", cmd_ready, 1'b1);
      chk1("done_once", done, 1'b0);
    end
    plan_contact();
    for (int t = 0; t <= int'(Busy); t++) begin
      @(negedge clk);
      cmd_valid = hold_valid;
      if (hold_valid) begin
        if (t >= 5) cmd_key = next_key;
      end else begin
        cmd_key = 4'($urandom);
      end
      if (col_mode == 0)      col = ~(4'b0001 << (t % 4));
      else if (col_mode == 1) col = ~(4'b0001 << (idx % 4));
      else if (col_mode == 2) col = 4'($urandom);
      else                    col = col_fix;
      #1;
      if (t < int'(Busy)) begin
        chk4("row", row, exp_row(key, m_contact[t], col));
        chk1("busy", busy, 1'b1);
        chk1("ready_busy", cmd_ready, 1'b0);
        chk1("done_busy", done, 1'b0);
        if (t == probe_t) chk4("table_row", row, probe_row);
        if (check_bounce) begin
          rb = row[idx / 4];
          if (t < int'(Bounce)) begin
            if (stage == 0 && !rb) stage = 1;
            else if (stage == 1 && rb) stage = 2;
            else if (stage == 2 && !rb) stage = 3;
            if (t == int'(Bounce) - 1) chk1("press_toggle", stage == 3, 1'b1);
          end
          if (t == int'(Bounce) - 2 || t == int'(Bounce) - 1) chk1("press_settled", rb, 1'b0);
          if (t == int'(2 * Bounce + Hold) - 2 || t == int'(2 * Bounce + Hold) - 1)
            chk1("release_settled", rb, 1'b1);
        end
        if (t == abort_t) begin
          #1 reset_n = 1'b0;
          #1;
          chk4("row_async_reset", row, 4'b1111);
          chk1("busy_in_reset", busy, 1'b0);
          chk1("ready_in_reset", cmd_ready, 1'b1);
          m_lfsr = Seed;
          return;
        end
      end else begin
        chk1("done_pulse", done, 1'b1);
        chk1("ready_after", cmd_ready, 1'b1);
        chk1("busy_after", busy, 1'b0);
        chk4("row_idle", row, 4'b1111);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    key_tab = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
    vecs[0]  = '{4'h5, 4'b1101, 4'b1101};
    vecs[1]  = '{4'h5, 4'b1110, 4'b1111};
    vecs[2]  = '{4'h5, 4'b1100, 4'b1101};
    vecs[3]  = '{4'h5, 4'b0000, 4'b1101};
    vecs[4]  = '{4'hD, 4'b0111, 4'b0111};
    vecs[5]  = '{4'hD, 4'b1011, 4'b1111};
    vecs[6]  = '{4'h0, 4'b1110, 4'b0111};
    vecs[7]  = '{4'h0, 4'b1101, 4'b1111};
    vecs[8]  = '{4'h1, 4'b1110, 4'b1110};
    vecs[9]  = '{4'h1, 4'b0111, 4'b1111};
    vecs[10] = '{4'hA, 4'b0111, 4'b1110};
    vecs[11] = '{4'hE, 4'b1011, 4'b0111};
    vecs[12] = '{4'h9, 4'b1011, 4'b1011};
    vecs[13] = '{4'hD, 4'b1111, 4'b1111};

    reset_n   = 1'b0;
    col       = 4'b1111;
    cmd_valid = 1'b0;
    cmd_key   = 4'h0;
    m_lfsr    = Seed;
    #3;
    chk4("reset_row", row, 4'b1111);
    chk1("reset_ready", cmd_ready, 1'b1);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Reset asserted mid-HOLD with key 5 and its column strobed.
    run_cmd(4'h5, 3, 4'b1101, 1'b0, 1'b0, 4'h0, 40, 4'b1101, 40, 1'b0);
    @(negedge clk);
    #1;
    chk4("row_held_reset", row, 4'b1111);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk1("ready_after_reset", cmd_ready, 1'b1);
    chk1("busy_after_reset", busy, 1'b0);

    // Bounce window from the seed, key column held low.
    run_cmd(4'h5, 1, 4'b1111, 1'b0, 1'b0, 4'h0, -1, 4'b1111, -1, 1'b1);

    // Single press with rotating strobes, then corner keys.
    run_cmd(4'h5, 0, 4'b1111, 1'b0, 1'b0, 4'h0, -1, 4'b1111, -1, 1'b0);
    run_cmd(4'hD, 0, 4'b1111, 1'b0, 1'b0, 4'h0, -1, 4'b1111, -1, 1'b0);
    run_cmd(4'h0, 0, 4'b1111, 1'b0, 1'b0, 4'h0, -1, 4'b1111, -1, 1'b0);
    run_cmd(4'h1, 0, 4'b1111, 1'b0, 1'b0, 4'h0, -1, 4'b1111, -1, 1'b0);

    for (int i = 0; i < 14; i++)
      run_cmd(vecs[i].key, 3, vecs[i].col, 1'b0, 1'b0, 4'h0, 60, vecs[i].row, -1, 1'b0);

    // cmd_valid held: key 3 then A accepted on the done cycle, nothing further.
    run_cmd(4'h3, 2, 4'b1111, 1'b0, 1'b1, 4'hA, -1, 4'b1111, -1, 1'b0);
    run_cmd(4'hA, 0, 4'b1111, 1'b1, 1'b0, 4'h0, 60, 4'b1111, -1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk1("no_third_accept", busy, 1'b0);
    end

    for (int i = 0; i < 16; i++)
      run_cmd(4'($urandom), int'($urandom_range(0, 2)), 4'b1111, 1'b0, 1'b0, 4'h0, -1,
              4'b1111, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
